// File: rtl/even_result_pipe.sv
// rtl/even_result_pipe.sv - fixed-depth result staging pipe with forwarding taps and in-order writeback
module even_result_pipe #(
   parameter int REG_ADDR_WD = 7,
   parameter int REG_DATA_WD = 128,
   parameter int NUM_STAGES  = 7,
   parameter int LAT_WD      = 3
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              in_valid,
   input  logic [REG_ADDR_WD-1:0]            in_RT_addr,
   input  logic [REG_DATA_WD-1:0]            in_RT_data,
   input  logic [LAT_WD-1:0]                 in_latency,
   input  logic                              flush,
   input  logic [REG_ADDR_WD-1:0]            chk_addr,
   output logic [NUM_STAGES-1:0]             fwd_valid,
   output logic [NUM_STAGES-1:0]             fwd_ready,
   output logic [NUM_STAGES*REG_ADDR_WD-1:0] fwd_addr,
   output logic [NUM_STAGES*REG_DATA_WD-1:0] fwd_data,
   output logic                              chk_pending,
   output logic                              wb_valid,
   output logic [REG_ADDR_WD-1:0]            wb_addr,
   output logic [REG_DATA_WD-1:0]            wb_data,
   output logic                              lat_err
);

   // Index 0 holds stage 1; index NUM_STAGES-1 feeds the register-file write port.
   logic [NUM_STAGES-1:0]  st_valid;
   logic [REG_ADDR_WD-1:0] st_addr [NUM_STAGES];
   logic [REG_DATA_WD-1:0] st_data [NUM_STAGES];
   logic [LAT_WD-1:0]      st_rem  [NUM_STAGES];

   logic              capture;
   logic              lat_bad;
   logic [LAT_WD-1:0] rem_in;

   assign capture = in_valid && !flush;
   assign lat_bad = (in_latency == '0) || (32'(in_latency) > 32'(NUM_STAGES));
   assign rem_in  = lat_bad ? LAT_WD'(NUM_STAGES - 1) : (in_latency - LAT_WD'(1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st_valid <= '0;
         lat_err  <= 1'b0;
         for (int k = 0; k < NUM_STAGES; k++) begin
            st_addr[k] <= '0;
            st_data[k] <= '0;
            st_rem[k]  <= '0;
         end
      end else begin
         lat_err     <= capture && lat_bad;
         st_valid[0] <= capture;
         st_addr[0]  <= in_RT_addr;
         st_data[0]  <= in_RT_data;
         st_rem[0]   <= capture ? rem_in : '0;
         // Unconditional shift: every entry travels the full depth, so writeback order matches issue order.
         for (int k = 1; k < NUM_STAGES; k++) begin
            st_valid[k] <= st_valid[k-1] && !flush;
            st_addr[k]  <= st_addr[k-1];
            st_data[k]  <= st_data[k-1];
            st_rem[k]   <= (st_rem[k-1] == '0) ? '0 : (st_rem[k-1] - LAT_WD'(1));
         end
      end
   end

   always_comb begin
      fwd_valid   = '0;
      fwd_ready   = '0;
      fwd_addr    = '0;
      fwd_data    = '0;
      chk_pending = 1'b0;
      for (int k = 0; k < NUM_STAGES; k++) begin
         fwd_valid[k]                          = st_valid[k];
         fwd_ready[k]                          = st_valid[k] && (st_rem[k] == '0);
         fwd_addr[k*REG_ADDR_WD +: REG_ADDR_WD] = st_addr[k];
         fwd_data[k*REG_DATA_WD +: REG_DATA_WD] = st_data[k];
         if (st_valid[k] && (st_rem[k] != '0) && (st_addr[k] == chk_addr))
            chk_pending = 1'b1;
      end
   end

   assign wb_valid = st_valid[NUM_STAGES-1];
   assign wb_addr  = st_addr[NUM_STAGES-1];
   assign wb_data  = st_data[NUM_STAGES-1];

endmodule

// File: tb/tb_even_result_pipe.sv
// tb/tb_even_result_pipe.sv - directed self-checking bench for even_result_pipe
module tb_even_result_pipe;
   localparam int AW = 7;
   localparam int DW = 128;
   localparam int NS = 7;
   localparam int LW = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic [AW-1:0]    in_RT_addr;
   logic [DW-1:0]    in_RT_data;
   logic [LW-1:0]    in_latency;
   logic             flush;
   logic [AW-1:0]    chk_addr;
   logic [NS-1:0]    fwd_valid;
   logic [NS-1:0]    fwd_ready;
   logic [NS*AW-1:0] fwd_addr;
   logic [NS*DW-1:0] fwd_data;
   logic             chk_pending;
   logic             wb_valid;
   logic [AW-1:0]    wb_addr;
   logic [DW-1:0]    wb_data;
   logic             lat_err;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [DW-1:0] DATA_A = 128'h00112233445566778899AABBCCDDEEFF;
   localparam logic [DW-1:0] DATA_B = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;

   even_result_pipe #(.REG_ADDR_WD(AW), .REG_DATA_WD(DW), .NUM_STAGES(NS), .LAT_WD(LW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_RT_addr(in_RT_addr),
      .in_RT_data(in_RT_data), .in_latency(in_latency), .flush(flush), .chk_addr(chk_addr),
      .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
      .chk_pending(chk_pending), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
      .lat_err(lat_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [LW-1:0] l);
      in_valid   = 1'b1;
      in_RT_addr = a;
      in_RT_data = d;
      in_latency = l;
   endtask

   initial begin
      rst = 1'b0; in_valid = 1'b0; in_RT_addr = '0; in_RT_data = '0;
      in_latency = '0; flush = 1'b0; chk_addr = '0;
      #3;
      check("reset_fwd_valid", DW'(fwd_valid), '0);
      check("reset_wb_valid", DW'(wb_valid), '0);
      check("reset_lat_err", DW'(lat_err), '0);
      step();
      rst = 1'b1;

      // Single capture with L=2
      drive(7'd5, DATA_A, 3'd2);
      step();
      in_valid = 1'b0;
      check("t1_valid_c1", DW'(fwd_valid), DW'(7'b0000001));
      check("t1_ready_c1", DW'(fwd_ready), '0);
      check("t1_addr_c1", DW'(fwd_addr[AW-1:0]), DW'(5));
      step();
      check("t1_ready_c2", DW'(fwd_ready), DW'(7'b0000010));
      for (int c = 3; c <= 8; c++) begin
         step();
         check($sformatf("t1_wb_valid_c%0d", c), DW'(wb_valid), DW'(c == 7));
         if (c == 7) begin
            check("t1_wb_addr", DW'(wb_addr), DW'(5));
            check("t1_wb_data", wb_data, DATA_A);
         end
      end

      // Back-to-back captures, addr 3/4/5 with L=1/4/7
      drive(7'd3, DW'(3), 3'd1);
      step();
      drive(7'd4, DW'(4), 3'd4);
      step();
      drive(7'd5, DW'(5), 3'd7);
      step();
      in_valid = 1'b0;
      check("t2_valid_c3", DW'(fwd_valid), DW'(7'b0000111));
      check("t2_ready_c3", DW'(fwd_ready), DW'(7'b0000100));
      check("t2_addr_c3", DW'(fwd_addr[3*AW-1:0]), DW'({7'd3, 7'd4, 7'd5}));
      for (int c = 4; c <= 10; c++) begin
         step();
         check($sformatf("t2_wb_valid_c%0d", c), DW'(wb_valid), DW'(c >= 7 && c <= 9));
         if (c >= 7 && c <= 9) begin
            check($sformatf("t2_wb_addr_c%0d", c), DW'(wb_addr), DW'(c - 4));
            check($sformatf("t2_wb_data_c%0d", c), wb_data, DW'(c - 4));
         end
         if (c <= 9)
            check($sformatf("t2_ready_a5_c%0d", c), DW'(fwd_ready[c-3]), DW'(c == 9));
      end

      // Hazard check on addr 9 with L=6
      chk_addr = 7'd9;
      #1;
      check("t3_pending_empty", DW'(chk_pending), '0);
      drive(7'd9, DW'(9), 3'd6);
      for (int c = 1; c <= 7; c++) begin
         step();
         in_valid = 1'b0;
         check($sformatf("t3_pending9_c%0d", c), DW'(chk_pending), DW'(c <= 5));
         chk_addr = 7'd10;
         #1;
         check($sformatf("t3_pending10_c%0d", c), DW'(chk_pending), '0);
         chk_addr = 7'd9;
      end
      step();

      // Illegal latency L=0 is treated as NUM_STAGES
      drive(7'd1, DW'(1), 3'd0);
      for (int c = 1; c <= 7; c++) begin
         step();
         in_valid = 1'b0;
         check($sformatf("t4_lat_err_c%0d", c), DW'(lat_err), DW'(c == 1));
         check($sformatf("t4_ready_c%0d", c), DW'(fwd_ready), (c == 7) ? DW'(7'b1000000) : '0);
      end
      step();
      drive(7'd2, DW'(2), 3'd7);
      step();
      in_valid = 1'b0;
      check("t4_lat7_no_err", DW'(lat_err), '0);
      check("t4_lat7_valid", DW'(fwd_valid), DW'(7'b0000001));
      for (int i = 0; i < 7; i++) step();

      // Flush with three entries in flight plus a simultaneous capture
      drive(7'd10, DW'(10), 3'd1);
      step();
      drive(7'd11, DW'(11), 3'd1);
      step();
      drive(7'd12, DW'(12), 3'd1);
      step();
      check("t5_valid_pre", DW'(fwd_valid), DW'(7'b0000111));
      drive(7'd13, DW'(13), 3'd0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      check("t5_valid_post", DW'(fwd_valid), '0);
      check("t5_lat_err_post", DW'(lat_err), '0);
      for (int c = 0; c < 10; c++) begin
         step();
         check($sformatf("t5_no_wb_%0d", c), DW'(wb_valid | (|fwd_valid)), '0);
      end

      // Asynchronous reset with four entries in flight
      for (int i = 0; i < 4; i++) begin
         drive(AW'(20 + i), DW'(20 + i), 3'd7);
         step();
      end
      in_valid = 1'b0;
      chk_addr = 7'd20;
      #1;
      check("t6_valid_pre", DW'(fwd_valid), DW'(7'b0001111));
      check("t6_pending_pre", DW'(chk_pending), DW'(1));
      #2;
      rst = 1'b0;
      #1;
      check("t6_valid_rst", DW'(fwd_valid), '0);
      check("t6_ready_rst", DW'(fwd_ready), '0);
      check("t6_pending_rst", DW'(chk_pending), '0);
      check("t6_wb_rst", DW'({wb_valid, wb_addr}), '0);
      check("t6_data_rst", fwd_data[DW-1:0], '0);
      step();
      step();
      rst = 1'b1;
      for (int c = 0; c < 9; c++) begin
         step();
         check($sformatf("t6_no_stale_wb_%0d", c), DW'(wb_valid), '0);
      end
      drive(7'd30, DATA_B, 3'd3);
      for (int c = 1; c <= 7; c++) begin
         step();
         in_valid = 1'b0;
         check($sformatf("t6_wb_valid_c%0d", c), DW'(wb_valid), DW'(c == 7));
      end
      check("t6_wb_addr", DW'(wb_addr), DW'(30));
      check("t6_wb_data", wb_data, DATA_B);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/even_result_pipe.md
# even_result_pipe

Result-staging pipeline that sits directly downstream of `even_pipe`. It captures each even-pipe result (`out_RT` plus destination address) in the issue cycle and carries it through `NUM_STAGES` registered stages. At each stage it exposes address, data and ready taps for forwarding and hazard detection. The result is presented to the register-file write port on exit. A per-instruction unit latency decides the stage at which a result becomes forwardable, which models the true latency of each even-pipe operation class.

## Interface
- `REG_ADDR_WD`, default 7: destination register address width.
- `REG_DATA_WD`, default 128: result data width.
- `NUM_STAGES`, default 7: number of stages; writeback latency in cycles.
- `LAT_WD`, default 3: width of the latency field.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  an even-pipe result is presented this cycle.
- `in_RT_addr`  in  REG_ADDR_WD  destination register.
- `in_RT_data`  in  REG_DATA_WD  result (`even_pipe.out_RT`).
- `in_latency`  in  LAT_WD  unit latency L; legal values are 1..NUM_STAGES.
- `flush`  in  1  synchronous kill of every in-flight entry.
- `chk_addr`  in  REG_ADDR_WD  issue-stage source register to hazard-check.
- `fwd_valid`  out  NUM_STAGES  bit k-1 is high when stage k holds a live entry.
- `fwd_ready`  out  NUM_STAGES  bit k-1 is high when the stage k entry is live and its result is forwardable.
- `fwd_addr`  out  NUM_STAGES*REG_ADDR_WD  packed per stage; stage 1 occupies the LSBs.
- `fwd_data`  out  NUM_STAGES*REG_DATA_WD  packed per stage; stage 1 occupies the LSBs.
- `chk_pending`  out  1  combinational; a live, not-ready entry matches `chk_addr`.
- `wb_valid`  out  1  register-file write enable.
- `wb_addr`  out  REG_ADDR_WD  register-file write address.
- `wb_data`  out  REG_DATA_WD  register-file write data.
- `lat_err`  out  1  registered one-cycle pulse when an illegal latency was accepted.

## Operation
- Each stage holds five fields: valid, addr, data, rem (a countdown of width LAT_WD) and ready, where ready = valid && rem==0.
- **Capture.** A capture occurs when `in_valid` is high and `flush` is low. On the next edge stage 1 loads valid=1, addr, data and rem=L-1.
- **Illegal latency.** If L==0 or L>NUM_STAGES, L is treated as NUM_STAGES. `lat_err` is set for exactly one cycle.
- **Shift.** On every edge, stage k+1 loads stage k unconditionally. There is no stall and no bubble collapse. rem becomes rem-1, saturating at 0.
- **Ordering.** Stage 1 loads valid=0 when there is no capture. Because every entry travels the same depth, writebacks are in order and can never collide.
- **Writeback.** `wb_*` are direct copies of stage NUM_STAGES. A result is written exactly once.
- **Ready progression.** An entry with latency L is not-ready in stages 1..L-1 and ready in stages L..NUM_STAGES.
- **Hazard check.** `chk_pending` is the OR over stages of (valid && !ready && addr==chk_addr). It is purely combinational on the registered state.
- **Forwarding priority.** Multiple live entries can share an address. The consumer gives priority to the lowest-numbered ready stage; this block does not deduplicate.
- **Flush.** On the edge, every stage's valid is cleared and any simultaneous capture is dropped (flush wins). addr and data may keep stale values, but every valid-gated output reads 0.
- **Reset.**
  - While `rst`==0, all stage fields are 0 regardless of `clk`.
  - As a result `fwd_*`, `wb_*`, `lat_err` and `chk_pending` are all 0.
  - Reset asserted mid-flight discards all entries with no writeback.

## Timing
- A result captured in cycle t appears in stage k during cycle t+k. `wb_valid` is high during cycle t+NUM_STAGES.
- With latency L, `fwd_ready` for the entry first rises in cycle t+L.
- `lat_err` is high during cycle t+1 only.
- Throughput is one result per cycle sustained. Back-to-back captures occupy consecutive stages.
- `chk_pending` is valid in the same cycle that `chk_addr` changes.
- If `flush` is asserted in cycle t, all `fwd_valid` and `wb_valid` bits read 0 in cycle t+1.
- Deassertion of `rst` is synchronised externally. The first capture is allowed on the first edge after release.

## Test plan
- **Single capture, L=2.** Capture addr=5, data=128'h0011…EEFF (byte i = 0x11·i) at cycle 0.
  - `fwd_valid[0]`=1 and `fwd_ready[0]`=0 at cycle 1.
  - `fwd_ready[1]`=1 at cycle 2.
  - At cycle 7: `wb_valid`=1, `wb_addr`=5, `wb_data` equal to the captured data.
- **Back-to-back captures.** Addr 3,4,5 with L=1,4,7 in cycles 0-2.
  - Writebacks occur in cycles 7,8,9 in that order.
  - `fwd_ready` for addr 5 is high only in stage 7.
- **Hazard check.** Capture addr=9 with L=6. Hold `chk_addr`=9.
  - `chk_pending`=1 in cycles 1-5 and 0 in cycle 6.
  - `chk_addr`=10 always gives 0.
- **Illegal latency.** Capture with L=0.
  - `lat_err`=1 in cycle 1 only.
  - The entry becomes ready only at stage 7.
  - L=7 does not raise `lat_err`.
- **Flush.** Load three entries, then assert `flush` together with `in_valid`.
  - All `fwd_valid`=0 next cycle.
  - No `wb_valid` pulse ever appears for the flushed entries or for the simultaneous capture.
- **Asynchronous reset.** Drive `rst` low between clock edges with 4 entries in flight.
  - All outputs read 0 immediately.
  - After release, no stale writeback occurs and a new capture writes back 7 cycles later.
